mem_rr_arbiter_2to1: RTL and testbench
======================================

// Module: mem_rr_arbiter_2to1
// PURPOSE
// - Shares one mem_req_t/mem_resp_t slave (RAM port behind cdc_mem_noc) between two masters (m0 = imem, m1 = dmem).
// - Round-robin request arbitration with grant lock for the whole request handshake.
// - In-order outstanding tracker routes every slave response back to the master that issued the request.
// - Replaces the fixed mem_noc path when both fetch and LSU target RAM.
// PARAMETERS
// - OUTST   2   max accepted-but-unanswered requests (depth of ID FIFO, power of 2, >=1)
// - CNT_W   $clog2(OUTST+1)   width of outstanding counter
// PORTS
// - clk            in   1          core clock
// - rstn           in   1          async reset, active low
// - m0_req_valid   in   1          master0 request valid
// - m0_req_ready   out  1          master0 request accepted
// - m0_req         in   mem_req_t  master0 request payload
// - m0_resp_valid  out  1          master0 response valid
// - m0_resp_ready  in   1          master0 can take response
// - m0_resp        out  mem_resp_t master0 response payload
// - m1_*           same as m0_*, master1
// - s_req_valid    out  1          slave request valid
// - s_req_ready    in   1          slave accepts request
// - s_req          out  mem_req_t  forwarded request
// - s_resp_valid   in   1          slave response valid
// - s_resp_ready   out  1          arbiter takes response
// - s_resp         in   mem_resp_t slave response
// - outst_cnt      out  CNT_W      requests in flight
// BEHAVIOUR
// - Clock and reset: one clock clk; rstn is asynchronous, active low.
// - Reset state: lock_q=0, last_q=1 (m0 wins first), FIFO empty, outst_cnt=0.
// - Reset outputs: all *_valid/*_ready outputs 0 while rstn=0.
// - Request path is combinational, 0-cycle latency.
//   - s_req = m[gnt]_req; s_req_valid = m[gnt]_req_valid & !full.
//   - m[gnt]_req_ready = s_req_ready & !full; the non-granted ready is 0.
// - Arbitration when unlocked:
//   - Only one master valid: that master wins.
//   - Both valid: winner is !last_q.
// - Lock: if s_req_valid & !s_req_ready, set lock_q=1 and hold gnt_q. Grant must not change until the handshake completes.
//   - This keeps valid/payload stable to the slave.
// - On a request handshake (s_req_valid & s_req_ready):
//   - Push gnt into ID FIFO.
//   - last_q <= gnt.
//   - lock_q <= 0.
// - full = (outst_cnt == OUTST). Full blocks new requests even if a pop happens in the same cycle, so there is no resp->req combinational path.
// - Response path is combinational:
//   - hid = FIFO head.
//   - m[hid]_resp_valid = s_resp_valid & !empty; m[hid]_resp = s_resp.
//   - s_resp_ready = m[hid]_resp_ready & !empty.
//   - The other master's resp_valid is 0.
// - Pop the FIFO on s_resp_valid & s_resp_ready.
// - outst_cnt: +1 on push, -1 on pop, unchanged on simultaneous push+pop.
//   - Never exceeds OUTST; never wraps below 0.
// - FIFO pointers are $clog2(OUTST)+1 bits with wrap; OUTST=1 degenerates to a single-entry register.
// - Empty FIFO: s_resp_ready=0. A response arriving with the FIFO empty is a protocol error (sim assertion fires); the arbiter does not pop.
// - Reset mid-transaction: FIFO, lock and counter clear immediately. Slave-side in-flight responses are lost; the system resets the slave in the same domain.
// - Request and response handshakes in the same cycle are independent.
// CONFIGURATION
// - MEM_ARB_RR_EN defined: round-robin as above.
// - MEM_ARB_RR_EN undefined: fixed priority, m1 (dmem) always wins when both are valid. last_q is unused, held at 1. Lock and tracker are unchanged.
// TESTING
// - Reset, then m0 valid only, s_req_ready=1 -> s_req=m0_req in same cycle, outst_cnt=1, head id=0.
// - m0+m1 valid each cycle, slave always ready, RR_EN -> grants alternate 0,1,0,1. Without RR_EN -> m1 every cycle.
// - m1 valid, s_req_ready=0 for 3 cycles, m0 raises valid in cycle 2 -> grant stays m1 until accepted, then m0 is served.
// - OUTST=2, two requests accepted (m0 then m1), no responses -> both req_ready=0. Responses then route to m0, then m1; outst_cnt goes 2,1,0.
// - Head master holds resp_ready=0 for 2 cycles -> s_resp_ready=0, FIFO holds, no response is misrouted to the other master.
// - rstn low with outst_cnt=2 -> outputs 0 asynchronously, outst_cnt=0. The first post-reset grant goes to m0.

Source files
------------

// File: rtl/mem_rr_arbiter_2to1_if.sv
// Memory request/response payload types and the master<->slave link
// interface used by mem_rr_arbiter_2to1.
package mem_rr_arbiter_2to1_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } mem_resp_t;
endpackage

// One request channel plus one response channel between a master and a slave.
interface mem_rr_arbiter_2to1_if;
  import mem_rr_arbiter_2to1_pkg::*;

  logic      req_valid;
  logic      req_ready;
  mem_req_t  req;
  logic      resp_valid;
  logic      resp_ready;
  mem_resp_t resp;

  modport master (output req_valid, req, resp_ready,
                  input  req_ready, resp_valid, resp);
  modport slave  (input  req_valid, req, resp_ready,
                  output req_ready, resp_valid, resp);
endinterface

// File: rtl/mem_rr_arbiter_2to1.sv
// Two-master to one-slave memory arbiter with grant lock and an in-order
// ID FIFO that routes each slave response back to the requesting master.
// Define MEM_ARB_RR_EN for round-robin; otherwise m1 has fixed priority.
module mem_rr_arbiter_2to1
  import mem_rr_arbiter_2to1_pkg::*;
#(
  parameter int unsigned OUTST = 2,
  parameter int unsigned CNT_W = $clog2(OUTST + 1)
) (
  input  logic                   clk,
  input  logic                   rstn,
  mem_rr_arbiter_2to1_if.slave   m0,
  mem_rr_arbiter_2to1_if.slave   m1,
  mem_rr_arbiter_2to1_if.master  s,
  output logic [CNT_W-1:0]       outst_cnt
);

  localparam int unsigned PTR_W = $clog2(OUTST) + 1;
  localparam int unsigned IDX_W = (OUTST > 1) ? $clog2(OUTST) : 1;

  logic             lock_q, lock_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             id_q [OUTST];
  logic             id_d [OUTST];

  logic             gnt, both_pick;
  logic             full, empty;
  logic             req_valid_c, resp_ready_c;
  logic             push, pop, hid;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  assign full   = (cnt_q == CNT_W'(OUTST));
  assign empty  = (cnt_q == '0);
  assign wr_idx = (OUTST == 1) ? '0 : IDX_W'(wr_ptr_q);
  assign rd_idx = (OUTST == 1) ? '0 : IDX_W'(rd_ptr_q);
  assign hid    = id_q[rd_idx];

`ifdef MEM_ARB_RR_EN
  assign both_pick = ~last_q;
`else
  // last_q is pinned to 1, so m1 always wins a tie.
  assign both_pick = last_q;
`endif

  // Grant selection: a locked grant is held until its handshake completes.
  always_comb begin
    gnt = gnt_q;
    if (!lock_q) begin
      if (m0.req_valid && !m1.req_valid)      gnt = 1'b0;
      else if (m1.req_valid && !m0.req_valid) gnt = 1'b1;
      else                                    gnt = both_pick;
    end
  end

  // Combinational request and response steering, forced idle in reset.
  always_comb begin
    req_valid_c  = rstn & ~full & (gnt ? m1.req_valid : m0.req_valid);
    resp_ready_c = rstn & ~empty & (hid ? m1.resp_ready : m0.resp_ready);

    s.req_valid   = req_valid_c;
    s.req         = gnt ? m1.req : m0.req;
    m0.req_ready  = rstn & ~full & s.req_ready & ~gnt;
    m1.req_ready  = rstn & ~full & s.req_ready &  gnt;

    s.resp_ready  = resp_ready_c;
    m0.resp_valid = rstn & ~empty & s.resp_valid & ~hid;
    m1.resp_valid = rstn & ~empty & s.resp_valid &  hid;
    m0.resp       = s.resp;
    m1.resp       = s.resp;

    push = req_valid_c & s.req_ready;
    pop  = s.resp_valid & resp_ready_c;
  end

  // Next-state for lock, round-robin history, ID FIFO and in-flight count.
  always_comb begin
    lock_d   = lock_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    id_d     = id_q;

    if (req_valid_c && !s.req_ready) begin
      lock_d = 1'b1;
      gnt_d  = gnt;
    end

    if (push) begin
      lock_d       = 1'b0;
      gnt_d        = gnt;
`ifdef MEM_ARB_RR_EN
      last_d       = gnt;
`endif
      id_d[wr_idx] = gnt;
      wr_ptr_d     = wr_ptr_q + PTR_W'(1);
    end

    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset leaves m0 as the first tie winner.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lock_q   <= 1'b0;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(OUTST); i++) id_q[i] <= 1'b0;
    end else begin
      lock_q   <= lock_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
    end
  end

  assign outst_cnt = cnt_q;

  // A slave response with nothing outstanding is a protocol error.
  a_resp_when_empty: assert property (@(posedge clk) disable iff (!rstn)
    !(s.resp_valid && empty));

endmodule

// File: tb/tb_mem_rr_arbiter_2to1.sv
// Scoreboard bench for mem_rr_arbiter_2to1: stimulus pushes expected
// grants/responses, a negedge monitor pops and compares on handshakes.
module tb_mem_rr_arbiter_2to1;
  import mem_rr_arbiter_2to1_pkg::*;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] outst_cnt;

  always #5 clk = ~clk;

  mem_rr_arbiter_2to1_if m0_if ();
  mem_rr_arbiter_2to1_if m1_if ();
  mem_rr_arbiter_2to1_if s_if ();

  mem_rr_arbiter_2to1 #(.OUTST(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .m0        (m0_if),
    .m1        (m1_if),
    .s         (s_if),
    .outst_cnt (outst_cnt)
  );

  typedef struct {
    bit          id;
    logic [31:0] val;
  } exp_t;

  exp_t exp_req[$];
  exp_t exp_resp[$];
  exp_t mon_e;
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit tie_gnt(input int i);
`ifdef MEM_ARB_RR_EN
    return bit'(i % 2);
`else
    return 1'b1;
`endif
  endfunction

  // Monitor: compare every request/response handshake against the scoreboard.
  always @(negedge clk) begin
    if (rstn) begin
      if (s_if.req_valid && s_if.req_ready) begin
        if (exp_req.size() == 0) chk("req_unexpected", 32'(s_if.req.addr), 32'hFFFF_FFFF);
        else begin
          mon_e = exp_req.pop_front();
          chk("req_gnt", 32'(m1_if.req_ready), 32'(mon_e.id));
          chk("req_addr", s_if.req.addr, mon_e.val);
        end
      end
      if (m0_if.resp_valid && m1_if.resp_valid) chk("resp_both_valid", 32'd1, 32'd0);
      if (m0_if.resp_valid && m0_if.resp_ready) begin
        if (exp_resp.size() == 0) chk("resp0_unexpected", s_if.resp.rdata, 32'hFFFF_FFFF);
        else begin
          mon_e = exp_resp.pop_front();
          chk("resp_master_m0", 32'd0, 32'(mon_e.id));
          chk("resp0_data", m0_if.resp.rdata, mon_e.val);
        end
      end
      if (m1_if.resp_valid && m1_if.resp_ready) begin
        if (exp_resp.size() == 0) chk("resp1_unexpected", s_if.resp.rdata, 32'hFFFF_FFFF);
        else begin
          mon_e = exp_resp.pop_front();
          chk("resp_master_m1", 32'd1, 32'(mon_e.id));
          chk("resp1_data", m1_if.resp.rdata, mon_e.val);
        end
      end
    end
  end

  task automatic idle();
    m0_if.req_valid = 1'b0; m0_if.req = '0; m0_if.resp_ready = 1'b0;
    m1_if.req_valid = 1'b0; m1_if.req = '0; m1_if.resp_ready = 1'b0;
    s_if.req_ready = 1'b0; s_if.resp_valid = 1'b0; s_if.resp = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic drive_req(input bit v0, input logic [31:0] a0,
                           input bit v1, input logic [31:0] a1, input bit rdy);
    m0_if.req_valid = v0; m0_if.req.addr = a0;
    m1_if.req_valid = v1; m1_if.req.addr = a1;
    s_if.req_ready  = rdy;
  endtask

  task automatic drive_resp(input logic [31:0] d, input bit r0, input bit r1);
    s_if.resp_valid = 1'b1; s_if.resp.rdata = d;
    m0_if.resp_ready = r0; m1_if.resp_ready = r1;
  endtask

  task automatic expect_req(input bit id, input logic [31:0] a);
    exp_req.push_back('{id: id, val: a});
  endtask

  task automatic expect_resp(input bit id, input logic [31:0] d);
    exp_resp.push_back('{id: id, val: d});
  endtask

  initial begin
    bit g;
    bit gp;
    idle();
    // Outputs held low in reset even with active inputs.
    #2;
    drive_req(1'b1, 32'h10, 1'b1, 32'h20, 1'b1);
    m0_if.resp_ready = 1'b1;
    #1;
    chk("rst_s_req_valid", 32'(s_if.req_valid), 32'd0);
    chk("rst_m0_req_ready", 32'(m0_if.req_ready), 32'd0);
    chk("rst_m1_req_ready", 32'(m1_if.req_ready), 32'd0);
    chk("rst_s_resp_ready", 32'(s_if.resp_ready), 32'd0);
    chk("rst_cnt", 32'(outst_cnt), 32'd0);
    do_reset();

    // Single m0 request, then its response routed back to m0.
    drive_req(1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    expect_req(1'b0, 32'h100);
    @(negedge clk);
    chk("t1_s_req_valid", 32'(s_if.req_valid), 32'd1);
    tick(); idle();
    chk("t1_cnt1", 32'(outst_cnt), 32'd1);
    drive_resp(32'hA0, 1'b1, 1'b1);
    expect_resp(1'b0, 32'hA0);
    @(negedge clk);
    chk("t1_m1_resp_valid", 32'(m1_if.resp_valid), 32'd0);
    tick(); idle();
    chk("t1_cnt0", 32'(outst_cnt), 32'd0);

    // Both masters always valid, slave always ready.
    do_reset();
    gp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle();
      g = tie_gnt(i);
      if (i < 4) begin
        drive_req(1'b1, 32'h200 + 32'(i), 1'b1, 32'h300 + 32'(i), 1'b1);
        expect_req(g, g ? 32'h300 + 32'(i) : 32'h200 + 32'(i));
      end
      if (i >= 1) begin
        drive_resp(32'hB0 + 32'(i), 1'b1, 1'b1);
        expect_resp(gp, 32'hB0 + 32'(i));
      end
      gp = g;
      tick();
    end
    idle();
    chk("t2_cnt0", 32'(outst_cnt), 32'd0);

    // Grant lock: m1 stalled for 3 cycles while m0 also asks.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_req(i > 0, 32'h500, 1'b1, 32'h400, 1'b0);
      @(negedge clk);
      chk("t3_s_req_addr", s_if.req.addr, 32'h400);
      chk("t3_m0_req_ready", 32'(m0_if.req_ready), 32'd0);
      chk("t3_s_req_valid", 32'(s_if.req_valid), 32'd1);
      tick();
    end
    drive_req(1'b1, 32'h500, 1'b1, 32'h400, 1'b1);
    expect_req(1'b1, 32'h400);
    tick();
    drive_req(1'b1, 32'h500, 1'b0, 32'h0, 1'b1);
    expect_req(1'b0, 32'h500);
    tick(); idle();
    chk("t3_cnt2", 32'(outst_cnt), 32'd2);

    // Full: requests blocked, even when a pop happens in the same cycle.
    drive_req(1'b1, 32'h600, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("t4_full_s_req_valid", 32'(s_if.req_valid), 32'd0);
    chk("t4_full_m0_ready", 32'(m0_if.req_ready), 32'd0);
    chk("t4_full_m1_ready", 32'(m1_if.req_ready), 32'd0);
    tick();
    drive_resp(32'hC0, 1'b1, 1'b1);
    expect_resp(1'b1, 32'hC0);
    @(negedge clk);
    chk("t4_pop_still_blocks", 32'(s_if.req_valid), 32'd0);
    tick(); idle();
    chk("t4_cnt1", 32'(outst_cnt), 32'd1);
    drive_resp(32'hC1, 1'b1, 1'b1);
    expect_resp(1'b0, 32'hC1);
    tick(); idle();
    chk("t4_cnt0", 32'(outst_cnt), 32'd0);

    // Head master stalls its response; nothing leaks to the other master.
    do_reset();
    drive_req(1'b1, 32'h700, 1'b0, 32'h0, 1'b1);
    expect_req(1'b0, 32'h700);
    tick(); idle();
    for (int i = 0; i < 2; i++) begin
      drive_resp(32'hD0, 1'b0, 1'b1);
      @(negedge clk);
      chk("t5_s_resp_ready", 32'(s_if.resp_ready), 32'd0);
      chk("t5_m1_resp_valid", 32'(m1_if.resp_valid), 32'd0);
      chk("t5_m0_resp_valid", 32'(m0_if.resp_valid), 32'd1);
      tick();
      chk("t5_cnt_hold", 32'(outst_cnt), 32'd1);
    end
    drive_resp(32'hD0, 1'b1, 1'b1);
    expect_resp(1'b0, 32'hD0);
    tick(); idle();
    chk("t5_cnt0", 32'(outst_cnt), 32'd0);

    // Asynchronous reset with two requests in flight.
    do_reset();
    drive_req(1'b1, 32'h800, 1'b0, 32'h0, 1'b1);
    expect_req(1'b0, 32'h800);
    tick();
    drive_req(1'b0, 32'h0, 1'b1, 32'h900, 1'b1);
    expect_req(1'b1, 32'h900);
    tick(); idle();
    chk("t6_cnt2", 32'(outst_cnt), 32'd2);
    drive_req(1'b1, 32'hA00, 1'b0, 32'h0, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("t6_async_cnt", 32'(outst_cnt), 32'd0);
    chk("t6_async_s_req_valid", 32'(s_if.req_valid), 32'd0);
    chk("t6_async_m0_ready", 32'(m0_if.req_ready), 32'd0);
    idle();
    @(posedge clk);
    #1 rstn = 1'b1;
    g = tie_gnt(0);
    drive_req(1'b1, 32'hB00, 1'b1, 32'hC00, 1'b1);
    expect_req(g, g ? 32'hC00 : 32'hB00);
    @(negedge clk);
    chk("t6_first_gnt", 32'(m1_if.req_ready), 32'(g));
    tick(); idle();
    tick();

    chk("req_queue_drained", 32'(exp_req.size()), 32'd0);
    chk("resp_queue_drained", 32'(exp_resp.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
